id_table_ram: RTL and testbench

Parametrised, synchronous, single-clock table RAM with one write port and one registered read port. It is the next-generation ID/attribute store for the sprite and tile pipeline. Over the fixed 32×24 table it adds four features: configurable width and depth, per-lane write masks, write-first read bypass, and a hardware clear sequencer. The sequencer fills every entry with a constant after reset or on request, so downstream logic never reads uninitialised IDs.

---
 rtl/id_ram_pkg.sv | 35 +++
 rtl/id_ram_clear_seq.sv | 55 +++++
 rtl/id_table_ram.sv | 104 ++++++++++
 tb/tb_id_table_ram.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ram_pkg.sv
// Shared types, defaults and the lane-merge helper for the ID/attribute table RAM.
package id_ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_e;

  localparam int DATA_W_DEF = 24;
  localparam int DEPTH_DEF  = 32;
  localparam int LANE_W_DEF = 8;

  // Widest entry/lane count the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W   = 256;
  localparam int LANES_MAX = 32;

  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0]   old_v,
    input logic [MERGE_W-1:0]   new_v,
    input logic [LANES_MAX-1:0] mask,
    input int                   lane_w
  );
    logic [MERGE_W-1:0] res;
    int                 lane;
    res = old_v;
    for (int i = 0; i < MERGE_W; i++) begin
      lane = i / lane_w;
      if (lane < LANES_MAX) begin
        if (mask[lane[$clog2(LANES_MAX)-1:0]]) res[i] = new_v[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/id_ram_clear_seq.sv
// Clear sequencer: walks clr_ptr over every entry after reset or on clear_req,
// owning the table write port while busy.
module id_ram_clear_seq
  import id_ram_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              seq_we,
  output logic [ADDR_W-1:0] seq_addr
);

  // Explicit end compare so non-power-of-two depths stop at the last real entry.
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        r_state;
  logic [ADDR_W-1:0] r_clr_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_clr_ptr == LAST) begin
            r_state   <= ST_IDLE;
            r_clr_ptr <= '0;
          end else begin
            r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
          end
        end
        default: begin
          r_state   <= ST_CLEAR;
          r_clr_ptr <= '0;
        end
      endcase
    end
  end

  assign busy     = (r_state == ST_CLEAR);
  assign seq_we   = busy;
  assign seq_addr = r_clr_ptr;

endmodule

// File: rtl/id_table_ram.sv
// Parametrised ID/attribute table: masked write port, registered write-first
// read port, and a clear sequencer that fills the table with FILL.
module id_table_ram
  import id_ram_pkg::*;
#(
  parameter int               DATA_W = DATA_W_DEF,
  parameter int               DEPTH  = DEPTH_DEF,
  parameter int               LANE_W = LANE_W_DEF,
  parameter logic [DATA_W-1:0] FILL  = '0,
  localparam int              ADDR_W = $clog2(DEPTH),
  localparam int              LANES  = DATA_W / LANE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LANES-1:0]  wr_mask,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic              w_busy;
  logic              w_seq_we;
  logic [ADDR_W-1:0] w_seq_addr;

  id_ram_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_req (clear_req),
    .busy      (w_busy),
    .seq_we    (w_seq_we),
    .seq_addr  (w_seq_addr)
  );

  assign busy = w_busy;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_in;
  logic              w_rd_in;
  logic              w_ext_we;
  logic [DATA_W-1:0] w_wr_old;
  logic [DATA_W-1:0] w_wr_merged;
  logic              w_seq_hit;
  logic              w_ext_hit;
  logic [DATA_W-1:0] w_rd_next;

  assign w_wr_in  = ({1'b0, wr_addr} < DEPTH_A);
  assign w_rd_in  = ({1'b0, rd_addr} < DEPTH_A);
  assign w_wr_old = w_wr_in ? r_mem[wr_addr] : FILL;

  // One merged value feeds both the array write and the same-address bypass.
  assign w_wr_merged = DATA_W'(lane_merge(MERGE_W'(w_wr_old), MERGE_W'(wr_data),
                                          LANES_MAX'(wr_mask), LANE_W));

  assign w_ext_we  = !w_busy && we && w_wr_in && (|wr_mask);
  assign w_seq_hit = w_seq_we && (w_seq_addr == rd_addr);
  assign w_ext_hit = w_ext_we && (wr_addr == rd_addr);

  always_comb begin
    w_rd_next = FILL;
    if (w_rd_in) begin
      if (w_seq_hit)      w_rd_next = FILL;
      else if (w_ext_hit) w_rd_next = w_wr_merged;
      else                w_rd_next = r_mem[rd_addr];
    end
  end

  // Storage: no reset; contents come only from the clear sequence and writes.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (w_seq_we)      r_mem[w_seq_addr] <= FILL;
      else if (w_ext_we) r_mem[wr_addr]    <= w_wr_merged;
    end
  end

  // Read stage p1
  logic [DATA_W-1:0] r_rd_data_p1;
  logic              r_vld_p1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vld_p1     <= 1'b0;
      r_rd_data_p1 <= '0;
    end else begin
      r_vld_p1 <= rd_en;
      if (rd_en) r_rd_data_p1 <= w_rd_next;
    end
  end

  assign rd_data  = r_rd_data_p1;
  assign rd_valid = r_vld_p1;

endmodule

// File: tb/tb_id_table_ram.sv
// Bench for id_table_ram: a DEPTH=32 instance and a DEPTH=20 instance driven in
// lockstep, with a reference model feeding per-instance expectation queues.
module tb_id_table_ram;

  localparam logic [23:0] FILL_A = 24'h000000;
  localparam logic [23:0] FILL_B = 24'h5A5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn_s [2];
  logic        cr_s   [2];
  logic        busy_s [2];
  logic        we_s   [2];
  logic        re_s   [2];
  logic        vld_s  [2];
  logic [4:0]  wa_s   [2];
  logic [4:0]  ra_s   [2];
  logic [23:0] wd_s   [2];
  logic [23:0] rd_s   [2];
  logic [2:0]  wm_s   [2];

  id_table_ram #(.DATA_W(24), .DEPTH(32), .LANE_W(8), .FILL(FILL_A)) u_a (
    .clk(clk), .reset_n(rstn_s[0]), .clear_req(cr_s[0]), .busy(busy_s[0]),
    .we(we_s[0]), .wr_addr(wa_s[0]), .wr_data(wd_s[0]), .wr_mask(wm_s[0]),
    .rd_en(re_s[0]), .rd_addr(ra_s[0]), .rd_data(rd_s[0]), .rd_valid(vld_s[0])
  );

  id_table_ram #(.DATA_W(24), .DEPTH(20), .LANE_W(8), .FILL(FILL_B)) u_b (
    .clk(clk), .reset_n(rstn_s[1]), .clear_req(cr_s[1]), .busy(busy_s[1]),
    .we(we_s[1]), .wr_addr(wa_s[1]), .wr_data(wd_s[1]), .wr_mask(wm_s[1]),
    .rd_en(re_s[1]), .rd_addr(ra_s[1]), .rd_data(rd_s[1]), .rd_valid(vld_s[1])
  );

  typedef struct {
    logic        vld;
    logic [23:0] data;
  } exp_t;

  typedef struct {
    bit          we;
    logic [4:0]  wa;
    logic [23:0] wd;
    logic [2:0]  wm;
    bit          re;
    logic [4:0]  ra;
    logic        vld;
    logic [23:0] data;
  } vec_t;

  logic [23:0] mem_m  [2][32];
  bit          mbusy  [2];
  int          mptr   [2];
  int          depth_m[2];
  logic [23:0] fill_m [2];
  logic [23:0] last_m [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [23:0] merge(input logic [23:0] o, input logic [23:0] n,
                                        input logic [2:0] m);
    logic [23:0] bm;
    bm = {{8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (n & bm) | (o & ~bm);
  endfunction

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input int i, input bit we, input logic [4:0] wa, input logic [23:0] wd,
                       input logic [2:0] wm, input bit re, input logic [4:0] ra, input bit cr,
                       input bit use_tab, input exp_t tab);
    exp_t        e;
    logic [23:0] rv;
    we_s[i] = we; wa_s[i] = wa; wd_s[i] = wd; wm_s[i] = wm;
    re_s[i] = re; ra_s[i] = ra; cr_s[i] = cr;
    if (!rstn_s[i]) begin
      e.vld = 1'b0; e.data = '0; last_m[i] = '0; mbusy[i] = 1'b1; mptr[i] = 0;
    end else begin
      if (re) begin
        if (int'(ra) >= depth_m[i])                             rv = fill_m[i];
        else if (mbusy[i] && int'(ra) == mptr[i])               rv = fill_m[i];
        else if (!mbusy[i] && we && wm != 3'b000 && wa == ra)   rv = merge(mem_m[i][ra], wd, wm);
        else                                                    rv = mem_m[i][ra];
        e.vld = 1'b1; e.data = rv; last_m[i] = rv;
      end else begin
        e.vld = 1'b0; e.data = last_m[i];
      end
      if (mbusy[i]) begin
        mem_m[i][mptr[i][4:0]] = fill_m[i];
        if (mptr[i] == depth_m[i] - 1) begin
          mbusy[i] = 1'b0; mptr[i] = 0;
        end else begin
          mptr[i]++;
        end
      end else begin
        if (we && int'(wa) < depth_m[i]) mem_m[i][wa] = merge(mem_m[i][wa], wd, wm);
        if (cr) begin
          mbusy[i] = 1'b1; mptr[i] = 0;
        end
      end
    end
    if (use_tab) e = tab;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    bit   have;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      have = 1'b0;
      if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      if (!have) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty dut=%0d actual=none required=entry", i);
      end else begin
        check($sformatf("rd_valid[%0d]", i), 24'(vld_s[i]), 24'(e.vld));
        check($sformatf("rd_data[%0d]", i), rd_s[i], e.data);
        check($sformatf("busy[%0d]", i), 24'(busy_s[i]), 24'(mbusy[i]));
      end
    end
  endtask

  task automatic cyc(input int i, input bit we, input logic [4:0] wa, input logic [23:0] wd,
                     input logic [2:0] wm, input bit re, input logic [4:0] ra, input bit cr);
    exp_t z;
    z.vld = 1'b0; z.data = '0;
    drive(i, we, wa, wd, wm, re, ra, cr, 1'b0, z);
    drive(1 - i, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, z);
    tick();
  endtask

  task automatic run_count(input int i, output int cnt);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy_s[i] !== 1'b1) break;
      cnt++;
      cyc(i, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  vec_t tab[12];

  initial begin
    int   c0, c1, cnt;
    exp_t te;
    exp_t z;
    z.vld = 1'b0; z.data = '0;
    depth_m[0] = 32; depth_m[1] = 20;
    fill_m[0]  = FILL_A; fill_m[1] = FILL_B;
    for (int i = 0; i < 2; i++) begin
      mbusy[i] = 1'b1; mptr[i] = 0; last_m[i] = '0; rstn_s[i] = 1'b0;
    end

    // Reset, then post-reset clear length on both instances
    cyc(0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    cyc(0, 1'b0, '0, '0, '0, 1'b1, 5'd2, 1'b0);
    rstn_s[0] = 1'b1; rstn_s[1] = 1'b1;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 100; k++) begin
      if (busy_s[0] !== 1'b1 && busy_s[1] !== 1'b1) break;
      if (busy_s[0] === 1'b1) c0++;
      if (busy_s[1] === 1'b1) c1++;
      cyc(0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    end
    check("reset_clear_cycles_d32", 24'(c0), 24'd32);
    check("reset_clear_cycles_d20", 24'(c1), 24'd20);

    for (int a = 0; a < 32; a++) begin
      drive(0, 1'b0, '0, '0, '0, 1'b1, 5'(a), 1'b0, 1'b0, z);
      drive(1, 1'b0, '0, '0, '0, 1'b1, 5'(a), 1'b0, 1'b0, z);
      tick();
    end

    // Masked writes and write-first bypass on the DEPTH=32 instance
    tab[0]  = '{1'b1, 5'd5,  24'hA1B2C3, 3'b111, 1'b0, 5'd0,  1'b0, 24'h000000};
    tab[1]  = '{1'b1, 5'd5,  24'hFFFFFF, 3'b010, 1'b0, 5'd0,  1'b0, 24'h000000};
    tab[2]  = '{1'b0, 5'd0,  24'h000000, 3'b000, 1'b1, 5'd5,  1'b1, 24'hA1FFC3};
    tab[3]  = '{1'b0, 5'd0,  24'h000000, 3'b000, 1'b0, 5'd0,  1'b0, 24'hA1FFC3};
    tab[4]  = '{1'b1, 5'd7,  24'hABCDEF, 3'b111, 1'b0, 5'd0,  1'b0, 24'hA1FFC3};
    tab[5]  = '{1'b1, 5'd7,  24'h123456, 3'b001, 1'b1, 5'd7,  1'b1, 24'hABCD56};
    tab[6]  = '{1'b0, 5'd0,  24'h000000, 3'b000, 1'b1, 5'd7,  1'b1, 24'hABCD56};
    tab[7]  = '{1'b1, 5'd9,  24'h112233, 3'b000, 1'b1, 5'd9,  1'b1, 24'h000000};
    tab[8]  = '{1'b0, 5'd0,  24'h000000, 3'b000, 1'b1, 5'd9,  1'b1, 24'h000000};
    tab[9]  = '{1'b1, 5'd31, 24'hDEADBE, 3'b100, 1'b1, 5'd31, 1'b1, 24'hDE0000};
    tab[10] = '{1'b1, 5'd0,  24'hCAFE01, 3'b111, 1'b1, 5'd0,  1'b1, 24'hCAFE01};
    tab[11] = '{1'b0, 5'd0,  24'h000000, 3'b000, 1'b1, 5'd1,  1'b1, 24'h000000};
    for (int k = 0; k < 12; k++) begin
      te.vld = tab[k].vld; te.data = tab[k].data;
      drive(0, tab[k].we, tab[k].wa, tab[k].wd, tab[k].wm, tab[k].re, tab[k].ra, 1'b0, 1'b1, te);
      drive(1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, z);
      tick();
    end

    // Fill table, then clear with a same-cycle write and writes on every busy cycle
    for (int a = 0; a < 32; a++)
      cyc(0, 1'b1, 5'(a), 24'(a) * 24'h010101 + 24'h102030, 3'b111, 1'b0, '0, 1'b0);
    cyc(0, 1'b1, 5'd3, 24'h777777, 3'b111, 1'b1, 5'd3, 1'b1);
    for (int k = 0; k < 100; k++) begin
      if (!mbusy[0]) break;
      cyc(0, 1'b1, 5'd3, 24'h111111, 3'b111, 1'b1, 5'd3, (k == 5));
    end
    for (int a = 0; a < 32; a++) cyc(0, 1'b0, '0, '0, '0, 1'b1, 5'(a), 1'b0);

    // Out-of-range access and clear length on the DEPTH=20 instance
    cyc(1, 1'b1, 5'd25, 24'h111111, 3'b111, 1'b1, 5'd25, 1'b0);
    cyc(1, 1'b1, 5'd19, 24'h0F0F0F, 3'b101, 1'b1, 5'd19, 1'b0);
    for (int a = 0; a < 32; a++) cyc(1, 1'b0, '0, '0, '0, 1'b1, 5'(a), 1'b0);
    cyc(1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    run_count(1, cnt);
    check("clear_req_cycles_d20", 24'(cnt), 24'd20);
    cyc(1, 1'b0, '0, '0, '0, 1'b1, 5'd19, 1'b0);

    // Reset at clr_ptr = 10 with a read in flight restarts the whole clear
    cyc(0, 1'b1, 5'd12, 24'h445566, 3'b111, 1'b0, '0, 1'b0);
    cyc(0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 100; k++) begin
      if (mptr[0] == 10 || !mbusy[0]) break;
      cyc(0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    end
    rstn_s[0] = 1'b0;
    cyc(0, 1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b0);
    rstn_s[0] = 1'b1;
    run_count(0, cnt);
    check("reset_midclear_cycles_d32", 24'(cnt), 24'd32);
    cyc(0, 1'b0, '0, '0, '0, 1'b1, 5'd12, 1'b0);
    cyc(0, 1'b0, '0, '0, '0, 1'b1, 5'd31, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
